read_bram: RTL and testbench

Streams a contiguous range of lines out of a BRAM onto an internal write-style stream. It is the source-side counterpart of the block that fills a BRAM from such a stream. An operation is started with a single config word holding offset and length. The block issues pipelined BRAM reads, buffers the returning data in a small credit-managed FIFO, and presents lines downstream under `out_almostfull` backpressure without losing data.

---
 rtl/read_bram.sv | 230 +++++++++++++++++++++++
 tb/tb_read_bram.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/read_bram.sv
// ---------------------------------------------------------------------------
// read_bram
//
// Streams a contiguous range of BRAM lines onto a write-style output stream.
// A single config word carries the start offset (bits 15:0) and the length in
// lines (bits 31:16). Reads are pipelined into the BRAM. Returning data lands
// in a small FIFO, and a read is only issued while a slot is reserved for its
// data. Lines are then drained downstream under out_almostfull backpressure.
//
// Ports:
//   clk            clock
//   reset          synchronous, active-high reset; aborts any operation
//   op_start       one-cycle start pulse, honoured only while idle
//   configreg      [15:0] start offset, [31:16] length in lines
//   bram_re        BRAM read enable (registered)
//   bram_raddr     BRAM read address (registered)
//   bram_rdata     BRAM read data, valid READ_LATENCY cycles after bram_re
//   out_we         output line valid (registered, single-cycle qualifier)
//   out_wdata      output line data (registered)
//   out_almostfull downstream cannot take more lines
//   busy           high while an operation is in progress
//   op_done        pulses together with the last out_we of an operation
// ---------------------------------------------------------------------------
module read_bram #(
  parameter int DATA_WIDTH   = 512,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_start,
  input  logic [31:0]           configreg,
  output logic                  bram_re,
  output logic [15:0]           bram_raddr,
  input  logic [DATA_WIDTH-1:0] bram_rdata,
  output logic                  out_we,
  output logic [DATA_WIDTH-1:0] out_wdata,
  input  logic                  out_almostfull,
  output logic                  busy,
  output logic                  op_done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [15:0] offset_q;
  logic [15:0] length_q;
  logic [15:0] issued_q;
  logic [15:0] sent_q;

  logic [READ_LATENCY-1:0] vld_pipe;
  logic [CNT_W-1:0]        inflight_q;

  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_count;

  logic [15:0]  cfg_offset;
  logic [15:0]  cfg_length;
  logic         start_ok;
  logic         credit_ok;
  logic [CNT_W:0] credit_sum;
  logic         issue;
  logic         last_issue;
  logic [15:0]  issue_addr;
  logic         push;
  logic         pop;
  logic         last_pop;

  assign cfg_offset = configreg[15:0];
  assign cfg_length = configreg[31:16];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. The IDLE start cycle already issues the first read, so
  // a one-line operation goes straight to DRAIN. DRAIN is left only after the
  // op_done pulse has been presented, which keeps busy high through op_done.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_next = (cfg_length == 16'd1) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        if (last_issue) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (op_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Per-cycle decisions for the read side and the output side. A read only
  // goes out when its data is guaranteed a FIFO slot: reads in flight plus
  // entries already buffered must leave room. In IDLE both are zero.
  always_comb begin
    start_ok   = 1'b0;
    issue      = 1'b0;
    last_issue = 1'b0;
    issue_addr = 16'd0;
    pop        = 1'b0;
    last_pop   = 1'b0;
    credit_sum = {1'b0, inflight_q} + {1'b0, fifo_count};
    credit_ok  = credit_sum < (CNT_W + 1)'(FIFO_DEPTH);
    push       = vld_pipe[READ_LATENCY-1];

    if (state == IDLE) begin
      start_ok = op_start && (cfg_length != 16'd0);
    end

    if (start_ok) begin
      issue      = 1'b1;
      issue_addr = cfg_offset;
      last_issue = (cfg_length == 16'd1);
    end else if (state == ISSUE && issued_q < length_q && credit_ok) begin
      issue      = 1'b1;
      issue_addr = offset_q + issued_q;
      last_issue = (issued_q + 16'd1 == length_q);
    end

    if (state != IDLE && fifo_count != '0 && !out_almostfull &&
        sent_q != length_q) begin
      pop      = 1'b1;
      last_pop = (sent_q + 16'd1 == length_q);
    end
  end

  // Operation bookkeeping: latched config and the issued/sent counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      offset_q <= 16'd0;
      length_q <= 16'd0;
      issued_q <= 16'd0;
      sent_q   <= 16'd0;
    end else begin
      if (state == IDLE && op_start) begin
        offset_q <= cfg_offset;
        length_q <= cfg_length;
        issued_q <= start_ok ? 16'd1 : 16'd0;
        sent_q   <= 16'd0;
      end else begin
        if (issue) begin
          issued_q <= issued_q + 16'd1;
        end
        if (pop) begin
          sent_q <= sent_q + 16'd1;
        end
      end
    end
  end

  // Read port and return tracking. The valid pipeline follows the registered
  // bram_re, so its last stage lines up with bram_rdata. Clearing it on reset
  // is what discards data from reads that were still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      bram_re    <= 1'b0;
      bram_raddr <= 16'd0;
      vld_pipe   <= '0;
      inflight_q <= '0;
    end else begin
      bram_re <= issue;
      if (issue) begin
        bram_raddr <= issue_addr;
      end
      vld_pipe[0] <= bram_re;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
      end
      inflight_q <= inflight_q + CNT_W'(issue) - CNT_W'(push);
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= bram_rdata;
    end
  end

  // FIFO pointers, occupancy and the registered output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      out_we     <= 1'b0;
      out_wdata  <= '0;
      op_done    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        out_wdata <= fifo_mem[rd_ptr];
      end
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      out_we     <= pop;
      op_done    <= last_pop;
      busy       <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_read_bram.sv
// ---------------------------------------------------------------------------
// tb_read_bram
//
// Directed bench for read_bram. A behavioural BRAM returns its own address as
// data after READ_LATENCY cycles (and junk when not read). A table of
// operations is run through one monitoring task; reset mid-transfer is a
// hand-written sequence.
// ---------------------------------------------------------------------------
module tb_read_bram;

  localparam int DW      = 512;
  localparam int LAT     = 2;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 2000;

  logic          clk;
  logic          reset;
  logic          op_start;
  logic [31:0]   configreg;
  logic          bram_re;
  logic [15:0]   bram_raddr;
  logic [DW-1:0] bram_rdata;
  logic          out_we;
  logic [DW-1:0] out_wdata;
  logic          out_almostfull;
  logic          busy;
  logic          op_done;

  int checks;
  int errors;

  localparam logic [DW-1:0] JUNK = {16{32'hBAD0BAD0}};

  logic [DW-1:0] rd_pipe [LAT];

  read_bram #(
    .DATA_WIDTH  (DW),
    .READ_LATENCY(LAT),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .op_start      (op_start),
    .configreg     (configreg),
    .bram_re       (bram_re),
    .bram_raddr    (bram_raddr),
    .bram_rdata    (bram_rdata),
    .out_we        (out_we),
    .out_wdata     (out_wdata),
    .out_almostfull(out_almostfull),
    .busy          (busy),
    .op_done       (op_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: memory[a] = a, data appears LAT cycles after bram_re.
  always @(posedge clk) begin
    rd_pipe[0] <= bram_re ? DW'(bram_raddr) : JUNK;
    for (int i = 1; i < LAT; i++) begin
      rd_pipe[i] <= rd_pipe[i-1];
    end
  end
  assign bram_rdata = rd_pipe[LAT-1];

  typedef struct {
    logic [15:0] off;
    logic [15:0] len;
    bit          af_mode;
    bit          inject;
    int          exp_lines;
    int          exp_last;
  } vec_t;

  task automatic apply_stimulus(input logic start, input logic [31:0] cfg,
                                input logic af, input logic rst);
    op_start       = start;
    configreg      = cfg;
    out_almostfull = af;
    reset          = rst;
  endtask

  task automatic check_output(input string name, input logic [DW-1:0] act,
                              input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one operation from the start pulse until the cycle after op_done
  // (or a fixed window when no lines are expected) and checks the result.
  task automatic run_op(input vec_t v);
    logic [15:0]   addr_q[$];
    logic [DW-1:0] data_q[$];
    logic [31:0]   cfg;
    logic [15:0]   a;
    logic          af;
    logic          af_prev;
    int re_cnt, we_cnt, done_cnt, done_bad, af_bad, credit_bad, busy_seen;
    int first_re, first_we, last_we, done_cycle, busy_after;
    bit stall_seen;
    re_cnt = 0; we_cnt = 0; done_cnt = 0; done_bad = 0; af_bad = 0;
    credit_bad = 0; busy_seen = 0; stall_seen = 0;
    first_re = -1; first_we = -1; last_we = -1; done_cycle = -1;
    busy_after = -1; af_prev = 1'b0;
    cfg = {v.len, v.off};
    $display("[TB] op offset=%0h length=%0d", v.off, v.len);
    apply_stimulus(1'b1, cfg, 1'b0, 1'b0);
    for (int c = 1; c <= TIMEOUT; c++) begin
      @(posedge clk);
      #1;
      if (busy) busy_seen = 1;
      if (bram_re) begin
        addr_q.push_back(bram_raddr);
        re_cnt++;
        if (first_re < 0) first_re = c;
      end else if (re_cnt > 0 && re_cnt < int'(v.len)) begin
        stall_seen = 1;
      end
      if (out_we) begin
        data_q.push_back(out_wdata);
        we_cnt++;
        last_we = c;
        if (first_we < 0) first_we = c;
        if (af_prev) af_bad++;
      end
      if (op_done) begin
        done_cnt++;
        done_cycle = c;
        if (!out_we || !busy) done_bad++;
      end
      if (re_cnt - we_cnt > DEPTH) credit_bad++;
      if (done_cycle > 0 && c == done_cycle + 1) begin
        busy_after = busy ? 1 : 0;
        break;
      end
      if (v.exp_lines == 0 && c == 12) break;
      if (v.af_mode) af = (c <= 20) ? 1'b1 : 1'($urandom_range(0, 1));
      else af = 1'b0;
      if (v.inject && c == 3) apply_stimulus(1'b1, {16'd2, 16'h0200}, af, 1'b0);
      else apply_stimulus(1'b0, cfg, af, 1'b0);
      af_prev = af;
    end
    apply_stimulus(1'b0, cfg, 1'b0, 1'b0);

    check_output("read_count", DW'(re_cnt), DW'(v.exp_lines));
    check_output("line_count", DW'(we_cnt), DW'(v.exp_lines));
    check_output("done_count", DW'(done_cnt), (v.exp_lines > 0) ? DW'(1) : DW'(0));
    for (int i = 0; i < v.exp_lines && i < addr_q.size(); i++) begin
      a = v.off + 16'(i);
      check_output("read_addr", DW'(addr_q[i]), DW'(a));
    end
    for (int i = 0; i < v.exp_lines && i < data_q.size(); i++) begin
      a = v.off + 16'(i);
      check_output("line_data", data_q[i], DW'(a));
    end
    if (v.exp_lines == 0) begin
      check_output("busy_idle", DW'(busy_seen), DW'(0));
    end else begin
      check_output("done_seen", DW'(done_cycle > 0), DW'(1));
      check_output("first_re_cycle", DW'(first_re), DW'(1));
      check_output("done_with_last_we", DW'(done_cycle), DW'(last_we));
      check_output("done_qualifiers", DW'(done_bad), DW'(0));
      check_output("busy_after_done", DW'(busy_after), DW'(0));
      check_output("af_respected", DW'(af_bad), DW'(0));
      check_output("credit_bound", DW'(credit_bad), DW'(0));
      if (!v.af_mode) check_output("first_we_cycle", DW'(first_we), DW'(LAT + 3));
      else check_output("re_stalled", DW'(stall_seen), DW'(1));
      if (v.exp_last > 0) check_output("last_we_cycle", DW'(last_we), DW'(v.exp_last));
    end
  endtask

  vec_t vecs[6];
  vec_t v6;

  initial begin
    checks = 0;
    errors = 0;
    // offset, length, backpressure, inject start, lines, last out_we cycle
    vecs[0] = '{16'h0010, 16'd4,  1'b0, 1'b0, 4,  8};
    vecs[1] = '{16'h0020, 16'd0,  1'b0, 1'b0, 0,  -1};
    vecs[2] = '{16'hFFFE, 16'd4,  1'b0, 1'b0, 4,  8};
    vecs[3] = '{16'h0300, 16'd64, 1'b1, 1'b0, 64, -1};
    vecs[4] = '{16'h0100, 16'd6,  1'b0, 1'b1, 6,  10};
    vecs[5] = '{16'h0500, 16'd1,  1'b0, 1'b0, 1,  5};

    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_bram_re", DW'(bram_re), DW'(0));
    check_output("rst_bram_raddr", DW'(bram_raddr), DW'(0));
    check_output("rst_out_we", DW'(out_we), DW'(0));
    check_output("rst_out_wdata", out_wdata, DW'(0));
    check_output("rst_busy", DW'(busy), DW'(0));
    check_output("rst_op_done", DW'(op_done), DW'(0));
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i]);
    end

    // Reset mid-transfer with reads in flight and lines already leaving.
    apply_stimulus(1'b1, {16'd20, 16'h0040}, 1'b0, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      apply_stimulus(1'b0, {16'd20, 16'h0040}, 1'b0, (c == 6));
    end
    @(posedge clk);
    #1;
    check_output("mid_rst_bram_re", DW'(bram_re), DW'(0));
    check_output("mid_rst_bram_raddr", DW'(bram_raddr), DW'(0));
    check_output("mid_rst_out_we", DW'(out_we), DW'(0));
    check_output("mid_rst_out_wdata", out_wdata, DW'(0));
    check_output("mid_rst_busy", DW'(busy), DW'(0));
    check_output("mid_rst_op_done", DW'(op_done), DW'(0));
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0);
    v6 = '{16'h0000, 16'd2, 1'b0, 1'b0, 2, 6};
    run_op(v6);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
